// File: rtl/fill_bar_renderer_pkg.sv
// Shared types and colour constants for the animated fill bar renderer.
// Imported by the level controller, pixel interface and top level.
package fill_bar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RISING,
    FULL,
    FALLING
  } state_t;

  typedef logic [11:0] color_t;

  localparam color_t BLACK = 12'h000;
  localparam color_t WHITE = 12'hFFF;

endpackage

// File: rtl/fill_bar_renderer_if.sv
// Pixel request / colour response bundle between the address
// generator (master) and the renderer (slave).
interface fill_bar_renderer_if #(
  parameter int ROW_W = 8,
  parameter int COL_W = 10
);
  import fill_bar_pkg::*;

  logic             pix_valid;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  color_t           color_data;
  logic             color_valid;

  modport master (
    output pix_valid, row, col,
    input  color_data, color_valid
  );

  modport slave (
    input  pix_valid, row, col,
    output color_data, color_valid
  );

endinterface

// File: rtl/fill_level_ctrl.sv
// Per-frame fill level state machine: rises while pressed,
// drains after release, saturating at 0 and BAR_H.
module fill_level_ctrl
  import fill_bar_pkg::*;
#(
  parameter int BAR_H     = 26,
  parameter int RISE_STEP = 2,
  parameter int FALL_STEP = 1,
  parameter int LW        = $clog2(BAR_H + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic          pressed,
  output logic [LW-1:0] fill_level
);

  localparam int XW = LW + 1;
  localparam logic [XW-1:0] TOP  = XW'(BAR_H);
  localparam logic [XW-1:0] RISE = XW'(RISE_STEP);
  localparam logic [XW-1:0] FALL = XW'(FALL_STEP);

  state_t        state;
  logic [XW-1:0] lvl_x;
  logic [XW-1:0] up_x;
  logic [XW-1:0] dn_x;

  // Saturation is tested before adding so the sum never wraps.
  always_comb begin
    lvl_x = {1'b0, fill_level};
    up_x  = (TOP - lvl_x <= RISE) ? TOP : lvl_x + RISE;
    dn_x  = (lvl_x <= FALL) ? '0 : lvl_x - FALL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fill_level <= '0;
    end else if (frame_tick) begin
      unique case (1'b1)
        pressed && (state == FULL): begin
          state <= FULL;
        end
        pressed && (state != FULL): begin
          fill_level <= up_x[LW-1:0];
          state      <= (up_x == TOP) ? FULL : RISING;
        end
        !pressed && (fill_level != '0): begin
          fill_level <= dn_x[LW-1:0];
          state      <= (dn_x == '0) ? IDLE : FALLING;
        end
        !pressed && (fill_level == '0): begin
          state <= IDLE;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: rtl/fill_bar_renderer.sv
// Two-stage per-pixel renderer for one animated fill bar.
// Define FILL_OUTLINE_EN to draw a 1-pixel outline around the bar.
module fill_bar_renderer
  import fill_bar_pkg::*;
#(
  parameter int     IMG_W         = 584,
  parameter int     IMG_H         = 167,
  parameter int     ROW_W         = 8,
  parameter int     COL_W         = 10,
  parameter int     BAR_X         = 325,
  parameter int     BAR_W         = 16,
  parameter int     BAR_Y_TOP     = 128,
  parameter int     BAR_H         = 26,
  parameter int     RISE_STEP     = 2,
  parameter int     FALL_STEP     = 1,
  parameter color_t FILL_COLOR    = WHITE,
  parameter color_t BG_COLOR      = BLACK,
  parameter color_t OUTLINE_COLOR = 12'h888,
  parameter int     LW            = $clog2(BAR_H + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               pressed,
  fill_bar_renderer_if.slave pix,
  output logic [LW-1:0]      fill_level
);

  localparam int MW = (ROW_W > COL_W) ? ROW_W : COL_W;
  localparam int AW = ((MW > LW) ? MW : LW) + 2;

  fill_level_ctrl #(
    .BAR_H    (BAR_H),
    .RISE_STEP(RISE_STEP),
    .FALL_STEP(FALL_STEP),
    .LW       (LW)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .pressed   (pressed),
    .fill_level(fill_level)
  );

  logic [AW-1:0] r_a;
  logic [AW-1:0] c_a;
  logic [AW-1:0] lv_a;
  logic          in_range;
  logic          in_rect;
  logic          fill_hit;

  // Fill test uses the level live this cycle, so a pixel
  // alongside frame_tick sees the pre-update level.
  always_comb begin
    r_a      = AW'(pix.row);
    c_a      = AW'(pix.col);
    lv_a     = AW'(fill_level);
    in_range = (r_a < AW'(IMG_H)) && (c_a < AW'(IMG_W));
    in_rect  = (r_a >= AW'(BAR_Y_TOP))
            && (r_a <  AW'(BAR_Y_TOP + BAR_H))
            && (c_a >= AW'(BAR_X))
            && (c_a <  AW'(BAR_X + BAR_W));
    fill_hit = (r_a + lv_a) >= AW'(BAR_Y_TOP + BAR_H);
  end

  logic s1_valid;
  logic s1_range;
  logic s1_rect;
  logic s1_fill;
  color_t px_color;

`ifdef FILL_OUTLINE_EN
  logic edge_hit;
  logic s1_edge;

  always_comb begin
    edge_hit = (r_a == AW'(BAR_Y_TOP))
            || (r_a == AW'(BAR_Y_TOP + BAR_H - 1))
            || (c_a == AW'(BAR_X))
            || (c_a == AW'(BAR_X + BAR_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_edge <= 1'b0;
    end else begin
      s1_edge <= edge_hit;
    end
  end

  always_comb begin
    px_color = BG_COLOR;
    if (s1_range && s1_rect && s1_edge) begin
      px_color = OUTLINE_COLOR;
    end else if (s1_range && s1_rect && s1_fill) begin
      px_color = FILL_COLOR;
    end
  end
`else
  always_comb begin
    px_color = BG_COLOR;
    if (s1_range && s1_rect && s1_fill) begin
      px_color = FILL_COLOR;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_range <= 1'b0;
      s1_rect  <= 1'b0;
      s1_fill  <= 1'b0;
    end else begin
      s1_valid <= pix.pix_valid;
      s1_range <= in_range;
      s1_rect  <= in_rect;
      s1_fill  <= fill_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix.color_valid <= 1'b0;
      pix.color_data  <= BLACK;
    end else begin
      pix.color_valid <= s1_valid;
      if (s1_valid) begin
        pix.color_data <= px_color;
      end
    end
  end

endmodule

// File: tb/tb_fill_bar_renderer.sv
// Randomised and directed bench for fill_bar_renderer with a
// frame-level behavioural model and a per-cycle compare process.
module tb_fill_bar_renderer;
  import fill_bar_pkg::*;

`ifdef FILL_OUTLINE_EN
  localparam logic [11:0] EDGE_FILL = 12'h888;
  localparam logic [11:0] EDGE_BG   = 12'h888;
`else
  localparam logic [11:0] EDGE_FILL = 12'hFFF;
  localparam logic [11:0] EDGE_BG   = 12'h000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       pressed = 1'b0;
  logic [4:0] fill_level;
  logic       chk = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  fill_bar_renderer_if pif ();

  fill_bar_renderer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .pressed   (pressed),
    .pix       (pif.slave),
    .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  function automatic int next_level(int l, logic p);
    if (p) return (l + 2 > 26) ? 26 : l + 2;
    return (l > 0) ? l - 1 : 0;
  endfunction

  function automatic logic [11:0] exp_color(int r, int c, int lvl);
    bit rect;
    if (r >= 167 || c >= 584) return 12'h000;
    rect = (r >= 128 && r < 154 && c >= 325 && c < 341);
`ifdef FILL_OUTLINE_EN
    if (rect && (r == 128 || r == 153 || c == 325 || c == 340))
      return 12'h888;
`endif
    if (rect && r >= 154 - lvl) return 12'hFFF;
    return 12'h000;
  endfunction

  // Expected outputs: level per frame, colours delayed two cycles.
  int          m_level;
  logic        p1_v, p2_v;
  logic [11:0] p1_c, p2_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_level <= 0;
      p1_v    <= 1'b0;
      p1_c    <= 12'h000;
      p2_v    <= 1'b0;
      p2_c    <= 12'h000;
    end else begin
      if (frame_tick) m_level <= next_level(m_level, pressed);
      p1_v <= pif.pix_valid;
      p1_c <= exp_color(int'(pif.row), int'(pif.col), m_level);
      p2_v <= p1_v;
      if (p1_v) p2_c <= p1_c;
    end
  end

  task automatic cmp(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      cmp("model_valid", 32'(pif.color_valid), 32'(p2_v));
      cmp("model_data", 32'(pif.color_data), 32'(p2_c));
      cmp("model_level", 32'(fill_level), 32'(m_level));
    end
  end

  task automatic tick(logic p);
    @(negedge clk);
    frame_tick = 1'b1;
    pressed = p;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic drive(int r, int c);
    pif.pix_valid = 1'b1;
    pif.row = 8'(r);
    pif.col = 10'(c);
  endtask

  task automatic pix_lit(string nm, int r, int c, logic [11:0] exp);
    @(negedge clk);
    drive(r, c);
    @(negedge clk);
    pif.pix_valid = 1'b0;
    @(negedge clk);
    cmp({nm, "_valid"}, 32'(pif.color_valid), 32'd1);
    cmp(nm, 32'(pif.color_data), 32'(exp));
  endtask

  initial begin
    pif.pix_valid = 1'b0;
    pif.row = '0;
    pif.col = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk = 1'b1;
    cmp("reset_level", 32'(fill_level), 32'd0);
    cmp("reset_valid", 32'(pif.color_valid), 32'd0);
    cmp("reset_data", 32'(pif.color_data), 32'h000);
    rst_n = 1'b1;

    for (int i = 1; i <= 13; i++) begin
      tick(1'b1);
      cmp("rise", 32'(fill_level), 32'(2 * i));
    end
    tick(1'b1);
    cmp("hold_full", 32'(fill_level), 32'd26);
    pix_lit("full_top_left", 128, 325, EDGE_FILL);

    for (int i = 1; i <= 26; i++) begin
      tick(1'b0);
      cmp("fall", 32'(fill_level), 32'(26 - i));
    end
    tick(1'b0);
    cmp("no_underflow", 32'(fill_level), 32'd0);

    tick(1'b1);
    tick(1'b1);
    cmp("level4", 32'(fill_level), 32'd4);
    pix_lit("bottom_right", 153, 340, EDGE_FILL);
    pix_lit("fill_edge_row", 150, 330, 12'hFFF);
    pix_lit("above_fill", 149, 330, 12'h000);
    pix_lit("right_of_bar", 150, 341, 12'h000);

    repeat (4) tick(1'b0);
    tick(1'b1);
    cmp("level2", 32'(fill_level), 32'd2);
    @(negedge clk);
    frame_tick = 1'b1;
    pressed = 1'b1;
    drive(151, 330);
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    pif.pix_valid = 1'b0;
    cmp("tick_same_cycle", 32'(pif.color_data), 32'h000);
    @(negedge clk);
    cmp("tick_next_cycle", 32'(pif.color_data), 32'hFFF);

    pix_lit("out_of_range", 200, 700, 12'h000);
    repeat (4) tick(1'b0);
    cmp("level0", 32'(fill_level), 32'd0);
    pix_lit("lvl0_corner", 128, 325, EDGE_BG);
    pix_lit("lvl0_inside", 140, 330, 12'h000);

    repeat (5) tick(1'b1);
    cmp("level10", 32'(fill_level), 32'd10);
    @(negedge clk);
    drive(150, 330);
    @(posedge clk);
    @(posedge clk);
    #2;
    cmp("pre_reset_data", 32'(pif.color_data), 32'hFFF);
    rst_n = 1'b0;
    #1;
    cmp("async_level", 32'(fill_level), 32'd0);
    cmp("async_valid", 32'(pif.color_valid), 32'd0);
    cmp("async_data", 32'(pif.color_data), 32'h000);
    @(negedge clk);
    pif.pix_valid = 1'b0;
    rst_n = 1'b1;
    pix_lit("after_reset", 140, 330, 12'h000);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 7) == 0);
      pressed = ($urandom_range(0, 2) != 0);
      pif.pix_valid = ($urandom_range(0, 3) != 0);
      pif.row = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(120, 160));
      pif.col = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                            : 10'($urandom_range(318, 348));
    end
    @(negedge clk);
    frame_tick = 1'b0;
    pif.pix_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
